hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage pipeline. It drives the write-enable and flush controls of the PC, the IF/ID register, the ID/EX register and the EX/MEM and MEM/WB registers. It resolves four conditions: data-memory wait states, load-use hazards, ID-stage control redirects (taken branch or jump) and instruction-memory wait states. It also tracks the stall cause, keeps saturating performance counters and runs a data-memory timeout watchdog.

## Interface
- CNT_W, 16, width of the performance counters
- WAIT_W, 8, width of the data-memory wait watchdog counter
- MAX_WAIT, 255, number of consecutive dmem-wait cycles that sets memTimeout; must be ≤ 2^WAIT_W−1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- IDrs, IDrt  in  5 each  source register fields of the instruction in IF/ID
- IDusesRt  in  1  ID instruction reads rt as a source
- EXMemRead  in  1  instruction in ID/EX is a load
- EXRt  in  5  destination register of that load
- IDBranchTaken, IDJump  in  1 each  control redirect resolved in ID this cycle
- imemReady  in  1  instruction memory returns valid data this cycle
- MEMAccess  in  1  instruction in EX/MEM accesses data memory
- dmemReady  in  1  data memory completes the access this cycle
- PCWrite  out  1  PC load enable
- IFtoIDWrite  out  1  IF/ID load enable
- IFtoIDFlush  out  1  IF/ID clear; the register gives this priority over write
- IDtoEXBubble  out  1  load zeros (nop) into ID/EX
- pipeHold  out  1  freeze ID/EX and EX/MEM
- MEMtoWBBubble  out  1  load nop into MEM/WB
- ctrlState  out  3  cause of the previous cycle: 0 RUN, 1 DMEM_WAIT, 2 LU_STALL, 3 REDIRECT, 4 IFETCH_WAIT
- stallCycles  out  CNT_W  saturating count of cycles with PCWrite=0
- flushCount  out  CNT_W  saturating count of REDIRECT cycles
- memTimeout  out  1  sticky watchdog error

## Operation
- Each cycle is classified into exactly one cause. When several conditions are true, the first match in this order wins:
  - DMEM_WAIT: MEMAccess & !dmemReady. Outputs: PCWrite=0, IFtoIDWrite=0, IFtoIDFlush=0, IDtoEXBubble=0, pipeHold=1, MEMtoWBBubble=1.
  - LU_STALL: EXMemRead & EXRt≠0 & (EXRt==IDrs | (IDusesRt & EXRt==IDrt)). Outputs: PCWrite=0, IFtoIDWrite=0, IFtoIDFlush=0, IDtoEXBubble=1, pipeHold=0.
  - REDIRECT: IDBranchTaken | IDJump. Outputs: PCWrite=1, IFtoIDWrite=1, IFtoIDFlush=1 (discards the wrong-path fetch), IDtoEXBubble=0.
  - IFETCH_WAIT: !imemReady. Outputs: PCWrite=0, IFtoIDWrite=1, IFtoIDFlush=1 (bubble enters ID), IDtoEXBubble=0.
  - RUN: none of the above. Outputs: PCWrite=1, IFtoIDWrite=1, all other controls 0.
- pipeHold=0 and MEMtoWBBubble=0 in every cause except DMEM_WAIT.
- Dependency on the branch operand overrides the redirect. A redirect coinciding with a load-use hazard is suppressed, and the branch is re-evaluated the next cycle. A redirect during DMEM_WAIT is also deferred, because ID is frozen.
- Register $0 never causes a load-use stall.
- Watchdog:
  - waitCnt increments on each DMEM_WAIT cycle and clears to 0 on any other cycle; it saturates at MAX_WAIT.
  - memTimeout sets when waitCnt==MAX_WAIT−1 at a DMEM_WAIT edge, i.e. on the MAX_WAIT-th consecutive wait cycle.
  - memTimeout stays set until rst. Control outputs are unaffected by it.
- Counters:
  - stallCycles increments on every edge where PCWrite=0.
  - flushCount increments on every REDIRECT edge.
  - Both hold at all-ones once saturated.

## Timing
- All control outputs are combinational from the current inputs, with zero latency. This is required because the pipeline registers sample them on the same edge.
- ctrlState, the counters, waitCnt and memTimeout are registered. ctrlState shows the cause of cycle N during cycle N+1.
- Reset values: ctrlState=RUN, stallCycles=0, flushCount=0, waitCnt=0, memTimeout=0.
- Control outputs during reset follow the combinational rules. The pipeline registers are held in reset independently.
- Reset asserted mid-wait clears waitCnt and memTimeout immediately, without waiting for a clock edge.
- Invariant: LU_STALL never occurs on two consecutive cycles unless a DMEM_WAIT intervenes. After the bubble, ID/EX holds a nop with EXMemRead=0.

## Test plan
- Load-use: EXMemRead=1, EXRt=5, IDrs=5 for one cycle. Required: PCWrite=0, IFtoIDWrite=0, IDtoEXBubble=1. Next cycle ctrlState=2 and stallCycles=1. Repeat with EXRt=0: no stall.
- Branch: IDBranchTaken=1 with no hazard. Required: IFtoIDFlush=1, PCWrite=1. Next cycle ctrlState=3 and flushCount=1. Repeat with the branch together with a load-use hazard on IDrt (IDusesRt=1): LU_STALL wins and IFtoIDFlush=0.
- Dmem wait: MEMAccess=1, dmemReady=0 for 3 cycles together with IDJump=1. Required: pipeHold=1, MEMtoWBBubble=1, PCWrite=0 each cycle, and flushCount unchanged. After dmemReady=1, the redirect takes effect.
- Imem wait: imemReady=0 for 2 cycles. Required: IFtoIDFlush=1, PCWrite=0 each cycle, and stallCycles increases by 2.
- Watchdog with MAX_WAIT=4: 4 consecutive DMEM_WAIT cycles set memTimeout after the 4th edge. A 3-cycle wait followed by a ready cycle leaves it clear. memTimeout stays set until rst, and asynchronous rst clears it with no clock.
- Saturation with CNT_W=4: 20 stall cycles leave stallCycles=15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath and the hazard controller.
// The master modport is the datapath side. The slave modport is the controller side.
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       IDrs;
   logic [4:0]       IDrt;
   logic             IDusesRt;
   logic             EXMemRead;
   logic [4:0]       EXRt;
   logic             IDBranchTaken;
   logic             IDJump;
   logic             imemReady;
   logic             MEMAccess;
   logic             dmemReady;
   logic             PCWrite;
   logic             IFtoIDWrite;
   logic             IFtoIDFlush;
   logic             IDtoEXBubble;
   logic             pipeHold;
   logic             MEMtoWBBubble;
   logic [2:0]       ctrlState;
   logic [CNT_W-1:0] stallCycles;
   logic [CNT_W-1:0] flushCount;
   logic             memTimeout;

   modport master (
      output IDrs, IDrt, IDusesRt, EXMemRead, EXRt, IDBranchTaken, IDJump,
             imemReady, MEMAccess, dmemReady,
      input  PCWrite, IFtoIDWrite, IFtoIDFlush, IDtoEXBubble, pipeHold,
             MEMtoWBBubble, ctrlState, stallCycles, flushCount, memTimeout
   );

   modport slave (
      input  IDrs, IDrt, IDusesRt, EXMemRead, EXRt, IDBranchTaken, IDJump,
             imemReady, MEMAccess, dmemReady,
      output PCWrite, IFtoIDWrite, IFtoIDFlush, IDtoEXBubble, pipeHold,
             MEMtoWBBubble, ctrlState, stallCycles, flushCount, memTimeout
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller. It produces zero-latency stall, flush and bubble
// controls, and keeps the registered cause, the saturating counters and the dmem watchdog.
module hazard_ctrl #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned WAIT_W   = 8,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  hz
);
   typedef enum logic [2:0] {
      RUN         = 3'd0,
      DMEM_WAIT   = 3'd1,
      LU_STALL    = 3'd2,
      REDIRECT    = 3'd3,
      IFETCH_WAIT = 3'd4
   } cause_t;

   cause_t             cause_c;
   cause_t             state_q;
   logic               lu_hazard_c;
   logic               pc_write_c;
   logic               if_id_write_c;
   logic               if_id_flush_c;
   logic               id_ex_bubble_c;
   logic               pipe_hold_c;
   logic               mem_wb_bubble_c;
   logic [CNT_W-1:0]   stall_q;
   logic [CNT_W-1:0]   flush_q;
   logic [WAIT_W-1:0]  wait_q;
   logic               timeout_q;

   // $0 is hardwired to zero, so a load into it can never create a real dependency
   assign lu_hazard_c = hz.EXMemRead && (hz.EXRt != 5'd0) &&
                        ((hz.EXRt == hz.IDrs) || (hz.IDusesRt && (hz.EXRt == hz.IDrt)));

   // Priority classification: a frozen pipe and a pending operand both defer redirects
   always_comb begin
      cause_c = RUN;
      if (hz.MEMAccess && !hz.dmemReady)      cause_c = DMEM_WAIT;
      else if (lu_hazard_c)                   cause_c = LU_STALL;
      else if (hz.IDBranchTaken || hz.IDJump) cause_c = REDIRECT;
      else if (!hz.imemReady)                 cause_c = IFETCH_WAIT;
   end

   always_comb begin
      pc_write_c      = 1'b1;
      if_id_write_c   = 1'b1;
      if_id_flush_c   = 1'b0;
      id_ex_bubble_c  = 1'b0;
      pipe_hold_c     = 1'b0;
      mem_wb_bubble_c = 1'b0;
      case (cause_c)
         DMEM_WAIT: begin
            pc_write_c      = 1'b0;
            if_id_write_c   = 1'b0;
            pipe_hold_c     = 1'b1;
            mem_wb_bubble_c = 1'b1;
         end
         LU_STALL: begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
         end
         REDIRECT: begin
            if_id_flush_c = 1'b1;
         end
         IFETCH_WAIT: begin
            pc_write_c    = 1'b0;
            if_id_flush_c = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         stall_q   <= '0;
         flush_q   <= '0;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= cause_c;
         if (!pc_write_c && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
         if ((cause_c == REDIRECT) && (flush_q != '1))
            flush_q <= flush_q + 1'b1;
         // The watchdog counts consecutive wait cycles. It trips on the MAX_WAIT-th one.
         if (cause_c == DMEM_WAIT) begin
            if (wait_q != WAIT_W'(MAX_WAIT))
               wait_q <= wait_q + 1'b1;
            if (wait_q == WAIT_W'(MAX_WAIT - 1))
               timeout_q <= 1'b1;
         end else begin
            wait_q <= '0;
         end
      end
   end

   assign hz.PCWrite       = pc_write_c;
   assign hz.IFtoIDWrite   = if_id_write_c;
   assign hz.IFtoIDFlush   = if_id_flush_c;
   assign hz.IDtoEXBubble  = id_ex_bubble_c;
   assign hz.pipeHold      = pipe_hold_c;
   assign hz.MEMtoWBBubble = mem_wb_bubble_c;
   assign hz.ctrlState     = state_q;
   assign hz.stallCycles   = stall_q;
   assign hz.flushCount    = flush_q;
   assign hz.memTimeout    = timeout_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. It runs directed scenarios and then random cycles
// against a cause/counter reference model. The small parameters make saturation reachable.
module tb_hazard_ctrl;
   localparam int unsigned CW   = 4;
   localparam int unsigned MAXW = 4;
   localparam int          CMAX = 15;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Reference model state
   int   m_state;
   int   m_stall;
   int   m_flush;
   int   m_wait;
   int   m_to;
   logic [5:0] exp_ctrl [5];

   hazard_ctrl_if #(.CNT_W(CW)) hif ();

   hazard_ctrl #(.CNT_W(CW), .WAIT_W(8), .MAX_WAIT(MAXW)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_in(input logic ma, input logic dr, input logic mr, input logic [4:0] ert,
                         input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic bt, input logic jp, input logic ir);
      hif.MEMAccess     = ma;
      hif.dmemReady     = dr;
      hif.EXMemRead     = mr;
      hif.EXRt          = ert;
      hif.IDrs          = rs;
      hif.IDrt          = rt;
      hif.IDusesRt      = ur;
      hif.IDBranchTaken = bt;
      hif.IDJump        = jp;
      hif.imemReady     = ir;
   endtask

   task automatic set_idle();
      set_in(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Cause codes: 0 RUN, 1 DMEM_WAIT, 2 LU_STALL, 3 REDIRECT, 4 IFETCH_WAIT. The first match wins.
   function automatic int ref_cause();
      logic dep;
      dep = hif.EXMemRead && hif.EXRt != 0 &&
            (hif.EXRt == hif.IDrs || (hif.IDusesRt && hif.EXRt == hif.IDrt));
      if (hif.MEMAccess && !hif.dmemReady) return 1;
      if (dep) return 2;
      if (hif.IDBranchTaken || hif.IDJump) return 3;
      if (!hif.imemReady) return 4;
      return 0;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < CMAX) ? v + 1 : v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
   endtask

   // Check the combinational controls, clock once, then check the registered state.
   task automatic step(input string tag);
      int c;
      logic [5:0] ctl;
      #1;
      c   = ref_cause();
      ctl = {hif.PCWrite, hif.IFtoIDWrite, hif.IFtoIDFlush, hif.IDtoEXBubble,
             hif.pipeHold, hif.MEMtoWBBubble};
      check({tag, ".ctrl"}, 32'(ctl), 32'(exp_ctrl[c]));
      @(posedge clk);
      #1;
      if (c == 1) begin
         if (m_wait == MAXW - 1) m_to = 1;
         if (m_wait < MAXW) m_wait++;
      end else begin
         m_wait = 0;
      end
      if (!exp_ctrl[c][5]) m_stall = sat_inc(m_stall);
      if (c == 3) m_flush = sat_inc(m_flush);
      m_state = c;
      check({tag, ".state"},   32'(hif.ctrlState),   32'(m_state));
      check({tag, ".stall"},   32'(hif.stallCycles), 32'(m_stall));
      check({tag, ".flush"},   32'(hif.flushCount),  32'(m_flush));
      check({tag, ".timeout"}, 32'(hif.memTimeout),  32'(m_to));
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check({tag, ".timeout"}, 32'(hif.memTimeout),  32'd0);
      check({tag, ".state"},   32'(hif.ctrlState),   32'd0);
      check({tag, ".stall"},   32'(hif.stallCycles), 32'd0);
      check({tag, ".flush"},   32'(hif.flushCount),  32'd0);
      #1 rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      // Order: PCWrite IFtoIDWrite IFtoIDFlush IDtoEXBubble pipeHold MEMtoWBBubble
      exp_ctrl[0] = 6'b110000;
      exp_ctrl[1] = 6'b000011;
      exp_ctrl[2] = 6'b000100;
      exp_ctrl[3] = 6'b111000;
      exp_ctrl[4] = 6'b011000;
      model_reset();
      set_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset.state",   32'(hif.ctrlState),   32'd0);
      check("reset.stall",   32'(hif.stallCycles), 32'd0);
      check("reset.flush",   32'(hif.flushCount),  32'd0);
      check("reset.timeout", 32'(hif.memTimeout),  32'd0);
      #2 rst = 1'b0;

      // Load-use hazard on rs
      set_in(1'b0, 1'b1, 1'b1, 5'd5, 5'd5, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      step("lu_rs");
      check("lu_rs.state2", 32'(hif.ctrlState),   32'd2);
      check("lu_rs.stall1", 32'(hif.stallCycles), 32'd1);
      // A load into $0 never stalls
      set_in(1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      step("lu_r0");

      // Taken branch with no hazard
      set_idle(); hif.IDBranchTaken = 1'b1;
      step("branch");
      check("branch.flush1", 32'(hif.flushCount), 32'd1);
      // A branch that depends on the load through rt is suppressed
      set_in(1'b0, 1'b1, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
      step("branch_lu");
      // With rt unused, the same fields give no hazard
      hif.IDusesRt = 1'b0;
      step("branch_nouse");

      // Dmem wait with a pending jump: the jump is deferred and takes effect once memory is ready
      set_in(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (3) step("dmem_jump");
      check("dmem_jump.flush_held", 32'(hif.flushCount), 32'd2);
      hif.dmemReady = 1'b1;
      step("dmem_release");

      // Imem wait for 2 cycles
      set_idle(); hif.imemReady = 1'b0;
      repeat (2) step("imem");

      // Watchdog: a 3-cycle wait then a ready cycle stays clear. A 4-cycle wait trips it.
      set_idle(); hif.MEMAccess = 1'b1; hif.dmemReady = 1'b0;
      repeat (3) step("wd3");
      hif.dmemReady = 1'b1;
      step("wd3_ready");
      check("wd3.clear", 32'(hif.memTimeout), 32'd0);
      hif.dmemReady = 1'b0;
      repeat (4) step("wd4");
      check("wd4.set", 32'(hif.memTimeout), 32'd1);
      set_idle();
      repeat (2) step("wd_sticky");
      hif.MEMAccess = 1'b1; hif.dmemReady = 1'b0;
      step("wd_mid");
      async_reset("wd_async");
      // The wait count must have been cleared by reset: 3 more waits must not trip
      repeat (3) step("wd_after_rst");
      set_idle();
      step("wd_after_rst_ready");

      // Saturation of the stall counter
      async_reset("sat_rst");
      set_idle(); hif.imemReady = 1'b0;
      repeat (20) step("sat");
      check("sat.stall15", 32'(hif.stallCycles), 32'd15);

      // Random traffic against the model
      async_reset("rand_rst");
      for (int i = 0; i < 300; i++) begin
         hif.MEMAccess     = ($urandom_range(0, 3) == 0);
         hif.dmemReady     = ($urandom_range(0, 2) != 0);
         hif.EXMemRead     = ($urandom_range(0, 1) == 0);
         hif.EXRt          = 5'($urandom_range(0, 3));
         hif.IDrs          = 5'($urandom_range(0, 3));
         hif.IDrt          = 5'($urandom_range(0, 3));
         hif.IDusesRt      = 1'($urandom_range(0, 1));
         hif.IDBranchTaken = ($urandom_range(0, 3) == 0);
         hif.IDJump        = ($urandom_range(0, 5) == 0);
         hif.imemReady     = ($urandom_range(0, 4) != 0);
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
